// File: rtl/cic_pkg.sv
// Shared defaults, gain-normalisation shift and FSM encoding for the CIC decimator
// control path.
package cic_pkg;

    localparam int CIC_N      = 6;
    localparam int CIC_R      = 128;
    localparam int CIC_W      = 44;
    localparam int GAIN_SHIFT = CIC_N * $clog2(CIC_R);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMB = 2'd1,
        ST_OUT  = 2'd2
    } cic_state_e;

endpackage

// File: rtl/cic_phase_cnt.sv
// Mod-R decimation phase counter; flags the one integrator sample in every R that is kept.
module cic_phase_cnt
    import cic_pkg::*;
#(
    parameter int R = CIC_R
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    output logic keep
);

    localparam int            PW   = $clog2(R);
    localparam logic [PW-1:0] LAST = PW'(R - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Advance on every integrator strobe; R is a power of two so the wrap is free.
    always_comb begin
        if (in_vld) begin
            phase_d = phase_q + PW'(1);
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign keep = in_vld & (phase_q == LAST);

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimation controller: keeps one sample in R and runs N comb stages over one subtractor.
// Build option CIC_GAIN_SHIFT_EN: normalise the R^N DC gain to 1 with an arithmetic shift.
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int N = CIC_N,
    parameter int R = CIC_R,
    parameter int W = CIC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] int_data,
    input  logic         out_rdy,
    input  logic         ovf_clr,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         ovf
);

    localparam int            KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

`ifdef CIC_GAIN_SHIFT_EN
    localparam int SHIFT = N * $clog2(R);

    function automatic logic [W-1:0] scale_out(input logic [W-1:0] v);
        scale_out = W'($signed(v) >>> SHIFT);
    endfunction
`else
    function automatic logic [W-1:0] scale_out(input logic [W-1:0] v);
        scale_out = v;
    endfunction
`endif

    cic_state_e    state_q;
    cic_state_e    state_d;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [W-1:0]  z_q [N];
    logic [W-1:0]  z_d [N];
    logic          out_vld_q;
    logic          out_vld_d;
    logic [W-1:0]  out_data_q;
    logic [W-1:0]  out_data_d;
    logic          busy_q;
    logic          busy_d;
    logic          ovf_q;
    logic          ovf_d;

    logic          keep_s;
    logic          hs_s;
    logic          drop_s;
    logic [W-1:0]  diff_s;

    cic_phase_cnt #(
        .R (R)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .in_vld (in_vld),
        .keep   (keep_s)
    );

    assign hs_s   = out_vld_q & out_rdy;
    assign diff_s = acc_q - z_q[k_q];

    // Sequencer: capture, one comb stage per cycle, hold result until accepted.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        z_d        = z_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        drop_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (keep_s) begin
                    state_d = ST_COMB;
                    k_d     = '0;
                    acc_d   = int_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMB: begin
                // Stage input is acc (x at k=0); the difference becomes the next stage input.
                z_d[k_q] = acc_q;
                acc_d    = diff_s;
                drop_s   = keep_s;
                if (k_q == K_LAST) begin
                    state_d    = ST_OUT;
                    k_d        = '0;
                    out_vld_d  = 1'b1;
                    out_data_d = scale_out(diff_s);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_OUT: begin
                if (hs_s) begin
                    out_vld_d = 1'b0;
                    if (keep_s) begin
                        state_d = ST_COMB;
                        k_d     = '0;
                        acc_d   = int_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    drop_s = keep_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                k_d       = '0;
                out_vld_d = 1'b0;
            end
        endcase

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, comb delay line and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            acc_q      <= '0;
            for (int i = 0; i < N; i++) begin
                z_q[i] <= '0;
            end
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            z_q        <= z_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed self-checking bench for cic_decim_ctrl (N=6, R=128, W=44), raw or shifted build.
module tb_cic_decim_ctrl;

`ifdef CIC_GAIN_SHIFT_EN
    localparam logic [43:0] EXP_127 = 44'd0;
    localparam logic [43:0] EXP_DC  = 44'd1;
    localparam logic [43:0] EXP_NEG = 44'hFFF_FFFF_FFFF;
`else
    localparam logic [43:0] EXP_127 = 44'd127;
    localparam logic [43:0] EXP_DC  = 44'h400_0000_0000;
    localparam logic [43:0] EXP_NEG = 44'hC00_0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic [43:0] int_data = 44'd0;
    logic        out_rdy = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        out_vld;
    logic [43:0] out_data;
    logic        busy;
    logic        ovf;

    int          total = 0;
    int          bad = 0;
    logic [6:0]  ph = 7'd0;
    logic [43:0] ig [6];
    int          nout;
    logic        seen;

    cic_decim_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .int_data (int_data),
        .out_rdy  (out_rdy),
        .ovf_clr  (ovf_clr),
        .out_vld  (out_vld),
        .out_data (out_data),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given strobe/data; returns #1 after the rising edge.
    task automatic step(input logic v, input logic [43:0] d);
        in_vld   = v;
        int_data = d;
        @(posedge clk);
        #1;
        if (v) ph = ph + 7'd1;
        in_vld = 1'b0;
    endtask

    // Six-stage integrator cascade fed with a constant +1.
    task automatic step_model();
        ig[0] = ig[0] + 44'd1;
        for (int s = 1; s < 6; s++) ig[s] = ig[s] + ig[s-1];
        step(1'b1, ig[5]);
    endtask

    initial begin
        // 1: reset held with in_vld toggling
        for (int i = 0; i < 3; i++) step(i == 1, 44'd55);
        check_val("rst_out_vld", out_vld, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;
        ph  = 7'd0;

        // 2: first sample, int_data = phase index, capture on the 128th strobe
        for (int i = 0; i < 128; i++) step(1'b1, 44'(i));
        check_val("first_busy", busy, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 44'd0);
        check_val("first_vld_early", out_vld, 0);
        step(1'b0, 44'd0);
        check_val("first_vld", out_vld, 1);
        check_val("first_data", out_data, EXP_127);
        out_rdy = 1'b1;
        step(1'b0, 44'd0);
        check_val("first_drain", out_vld, 0);
        check_val("first_idle", busy, 0);

        // 3: DC gain from the integrator model, checked once the combs have flushed
        for (int s = 0; s < 6; s++) ig[s] = 44'd0;
        nout = 0;
        for (int i = 0; i < 1500 && nout < 10; i++) begin
            step_model();
            if (out_vld) begin
                nout++;
                if (nout >= 8) check_val("dc_gain", out_data, EXP_DC);
            end
        end
        check_val("dc_count", nout, 10);

        // 4: backpressure across the next capture
        out_rdy = 1'b0;
        step_model();
        check_val("bp_ovf_pre", ovf, 0);
        for (int i = 0; i < 200 && ph != 7'd0; i++) step_model();
        check_val("bp_vld", out_vld, 1);
        check_val("bp_data", out_data, EXP_DC);
        check_val("bp_ovf", ovf, 1);
        ovf_clr = 1'b1;
        step_model();
        ovf_clr = 1'b0;
        check_val("bp_ovf_clr", ovf, 0);

        // 5: handshake in the same cycle as a capture
        for (int i = 0; i < 200 && ph != 7'd127; i++) step_model();
        out_rdy = 1'b1;
        step_model();
        out_rdy = 1'b0;
        check_val("b2b_ovf", ovf, 0);
        check_val("b2b_vld_drop", out_vld, 0);
        check_val("b2b_busy", busy, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 44'd0);
        check_val("b2b_vld_early", out_vld, 0);
        step(1'b0, 44'd0);
        check_val("b2b_vld", out_vld, 1);
        out_rdy = 1'b1;
        step(1'b0, 44'd0);
        check_val("b2b_drain", out_vld, 0);

        // 6: asynchronous reset while the comb is at stage 3
        for (int i = 0; i < 200 && ph != 7'd127; i++) step(1'b1, 44'd9);
        step(1'b1, 44'h0AB_CDEF_0123);
        for (int i = 0; i < 3; i++) step(1'b0, 44'd0);
        check_val("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        ph = 7'd0;
        check_val("mid_busy_rst", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 44'd0);
            if (out_vld) seen = 1'b1;
        end
        check_val("mid_no_out", seen, 0);
        for (int i = 0; i < 127; i++) step(1'b1, 44'(i * 3 + 1));
        step(1'b1, 44'hC00_0000_0000);
        for (int i = 0; i < 5; i++) step(1'b0, 44'd0);
        check_val("mid_vld_early", out_vld, 0);
        step(1'b0, 44'd0);
        check_val("mid_vld", out_vld, 1);
        check_val("mid_data", out_data, EXP_NEG);
        check_val("mid_ovf", ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
